// File: rtl/core_pkg.sv
// Shared types and constants for the memory-access / writeback stage.
package core_pkg;

    typedef enum logic [2:0] {
        WB_ALU = 3'd0,
        WB_MEM = 3'd1,
        WB_PC4 = 3'd2,
        WB_IMM = 3'd3
    } wb_sel_e;

    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0011;
    localparam logic [3:0] SIZE_W = 4'b1111;

    // REQ2/RSP2 are only reachable when CORE_MISALIGNED_SPLIT_EN is defined.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RSP  = 3'd2,
        REQ2 = 3'd3,
        RSP2 = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_data_formatter.sv
// Extracts the addressed bytes from one or two bus beats and sign/zero-extends them.
module load_data_formatter
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_lo_i,
    input  logic [XLEN-1:0] rdata_hi_i,
    input  logic [1:0]      offset_i,
    input  logic [3:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] word;
    logic            sign_b;
    logic            sign_h;

    // The high beat only contributes bytes when an access straddles a word.
    assign word   = XLEN'({rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000});
    assign sign_b = ~unsigned_i & word[7];
    assign sign_h = ~unsigned_i & word[15];

    always_comb begin
        data_o = word;
        case (size_i)
            SIZE_B:  data_o = {{(XLEN-8){sign_b}}, word[7:0]};
            SIZE_H:  data_o = {{(XLEN-16){sign_h}}, word[15:0]};
            default: data_o = word;
        endcase
    end

endmodule

// File: rtl/core_mem_wb_stage.sv
// Memory-access and writeback stage: drives the req/gnt/rvalid data bus and the regfile write port.
// Optional CORE_MISALIGNED_SPLIT_EN splits misaligned accesses into two aligned beats.
module core_mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            reg_write_i,
    input  logic [2:0]      mem_to_reg_i,
    input  logic [3:0]      d_size_i,
    input  logic            d_unsigned_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_dout_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_reg_write_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] rd_din_o,
    output logic            misaligned_o
);

    lsu_state_e      state_q;
    logic [XLEN-1:0] addr_q, wdata_lo_q, wdata_hi_q, wbval_q, rdata_lo_q, rd_din_q;
    logic [3:0]      be_lo_q, be_hi_q, size_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q, wb_rd_q;
    logic [2:0]      m2r_q;
    logic            we_q, split_q, uns_q, rw_q, wb_we_q, mis_q;

    logic [1:0]        off_d;
    logic [7:0]        be_d;
    logic [2*XLEN-1:0] wdata_shift_d;
    logic [XLEN-1:0]   wdata_rep_d, wdata_lo_d, wbval_d, load_data, fmt_lo;
    logic              is_mem_d, misaligned_d, wb_we_final;

    assign off_d         = alu_result_i[1:0];
    assign be_d          = {4'b0000, d_size_i} << off_d;
    assign wdata_shift_d = {{XLEN{1'b0}}, rs2_dout_i} << {off_d, 3'b000};
    assign is_mem_d      = mem_read_i | mem_write_i;
    assign misaligned_d  = ((d_size_i == SIZE_H) && off_d[0]) ||
                           ((d_size_i == SIZE_W) && (off_d != 2'b00));
    assign wdata_lo_d    = misaligned_d ? wdata_shift_d[XLEN-1:0] : wdata_rep_d;
    assign wb_we_final   = rw_q && (rd_q != 5'd0);

    always_comb begin
        wdata_rep_d = rs2_dout_i;
        case (d_size_i)
            SIZE_B:  wdata_rep_d = {(XLEN/8){rs2_dout_i[7:0]}};
            SIZE_H:  wdata_rep_d = {(XLEN/16){rs2_dout_i[15:0]}};
            default: wdata_rep_d = rs2_dout_i;
        endcase
    end

    always_comb begin
        wbval_d = alu_result_i;
        case (mem_to_reg_i)
            WB_PC4:  wbval_d = pc_plus4_i;
            WB_IMM:  wbval_d = imm_i;
            default: wbval_d = alu_result_i;
        endcase
    end

    assign fmt_lo = (state_q == RSP2) ? rdata_lo_q : dmem_rdata_i;

    load_data_formatter #(.XLEN(XLEN)) u_fmt (
        .rdata_lo_i (fmt_lo),
        .rdata_hi_i (dmem_rdata_i),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_lo_q <= '0;
            wdata_hi_q <= '0;
            wbval_q    <= '0;
            rdata_lo_q <= '0;
            rd_din_q   <= '0;
            be_lo_q    <= '0;
            be_hi_q    <= '0;
            size_q     <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            wb_rd_q    <= '0;
            m2r_q      <= '0;
            we_q       <= 1'b0;
            split_q    <= 1'b0;
            uns_q      <= 1'b0;
            rw_q       <= 1'b0;
            wb_we_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            wb_we_q <= 1'b0;
            mis_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i && !is_mem_d) begin
                        wb_we_q  <= reg_write_i && (rd_i != 5'd0);
                        wb_rd_q  <= rd_i;
                        rd_din_q <= wbval_d;
`ifndef CORE_MISALIGNED_SPLIT_EN
                    end else if (valid_i && misaligned_d) begin
                        mis_q <= 1'b1;
`endif
                    end else if (valid_i) begin
                        state_q    <= REQ;
                        addr_q     <= {alu_result_i[XLEN-1:2], 2'b00};
                        be_lo_q    <= be_d[3:0];
                        be_hi_q    <= be_d[7:4];
                        wdata_lo_q <= wdata_lo_d;
                        wdata_hi_q <= wdata_shift_d[2*XLEN-1:XLEN];
                        we_q       <= mem_write_i && !mem_read_i;
                        split_q    <= misaligned_d;
                        off_q      <= off_d;
                        size_q     <= d_size_i;
                        uns_q      <= d_unsigned_i;
                        rd_q       <= rd_i;
                        rw_q       <= reg_write_i;
                        m2r_q      <= mem_to_reg_i;
                        wbval_q    <= wbval_d;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        if (!we_q)        state_q <= RSP;
                        else if (split_q) state_q <= REQ2;
                        else              state_q <= IDLE;
                    end
                end
                RSP: begin
                    if (dmem_rvalid_i && split_q) begin
                        rdata_lo_q <= dmem_rdata_i;
                        state_q    <= REQ2;
                    end else if (dmem_rvalid_i) begin
                        wb_we_q  <= wb_we_final;
                        wb_rd_q  <= rd_q;
                        rd_din_q <= (m2r_q == WB_MEM) ? load_data : wbval_q;
                        state_q  <= IDLE;
                    end
                end
                REQ2: begin
                    if (dmem_gnt_i) state_q <= we_q ? IDLE : RSP2;
                end
                RSP2: begin
                    if (dmem_rvalid_i) begin
                        wb_we_q  <= wb_we_final;
                        wb_rd_q  <= rd_q;
                        rd_din_q <= (m2r_q == WB_MEM) ? load_data : wbval_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o        = (state_q == IDLE);
    assign dmem_req_o     = (state_q == REQ) || (state_q == REQ2);
    assign dmem_we_o      = dmem_req_o && we_q;
    assign dmem_addr_o    = (state_q == REQ2) ? addr_q + XLEN'(4) : addr_q;
    assign dmem_be_o      = (state_q == REQ2) ? be_hi_q : be_lo_q;
    assign dmem_wdata_o   = (state_q == REQ2) ? wdata_hi_q : wdata_lo_q;
    assign wb_reg_write_o = wb_we_q;
    assign wb_rd_o        = wb_rd_q;
    assign rd_din_o       = rd_din_q;
    assign misaligned_o   = mis_q;

endmodule
